// File: rtl/calc_pkg.sv
// Shared calculator types: BCD digit, binary-to-decimal FSM states, and sizing helper.
package calc_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } b2d_state_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;

  // Decimal digits needed for a w-bit unsigned value: ceil(w*log10(2)), fixed-point log10(2).
  function automatic int ceil_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit >= 5 before the next left shift.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  assign d_o = (d_i >= BCD_ADJ_THRESH) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/product_to_bcd.sv
// Sequential double-dabble converter: signed/unsigned binary product to sign + magnitude packed BCD.
module product_to_bcd
  import calc_pkg::*;
#(
  parameter int IN_WIDTH = 64,
  parameter int DIGITS   = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   product,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [4:0]            ndigits
);

  localparam int CNT_W = $clog2(IN_WIDTH);

  if (IN_WIDTH < 2 || DIGITS < ceil_digits(IN_WIDTH) || DIGITS > 31) begin : g_param_check
    $error("product_to_bcd: DIGITS too small for IN_WIDTH or out of ndigits range");
  end

  b2d_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]   mag_q, mag_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d, adj;
  logic                  neg_q, neg_d;
  logic [4:0]            nd_q, nd_d, nd_enc;
  logic                  in_neg;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i(bcd_q[4*gi +: 4]),
      .d_o(adj[4*gi +: 4])
    );
  end

  // Highest nonzero digit wins; an all-zero result still reports one digit.
  always_comb begin
    nd_enc = 5'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) nd_enc = 5'(i + 1);
    end
  end

  assign in_neg = is_signed & product[IN_WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    nd_d    = nd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Negation at full width yields 2^(IN_WIDTH-1) unsigned for the most negative input.
          mag_d   = in_neg ? -product : product;
          neg_d   = in_neg;
          bcd_d   = '0;
          cnt_d   = CNT_W'(IN_WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {adj[4*DIGITS-2:0], mag_q[IN_WIDTH-1]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = COUNT;
      end
      COUNT: begin
        nd_d    = nd_enc;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      nd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      nd_q    <= nd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign ndigits   = nd_q;

endmodule

// File: tb/tb_product_to_bcd.sv
// Self-checking bench for product_to_bcd: spec vector table, random vs. division model, corner sequences.
module tb_product_to_bcd;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] product;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] bcd;
  logic        neg;
  logic [4:0]  ndigits;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  product_to_bcd #(.IN_WIDTH(64), .DIGITS(20)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .neg(neg), .ndigits(ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] p;
    logic        s;
    logic [79:0] b;
    logic        n;
    logic [4:0]  nd;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by repeated division of the magnitude.
  function automatic void model(input logic [63:0] p, input logic s,
                                output logic [79:0] b, output logic n, output logic [4:0] nd);
    logic [63:0] m;
    n  = s & p[63];
    m  = n ? (~p + 64'd1) : p;
    b  = '0;
    nd = 5'd1;
    for (int i = 0; i < 20; i++) begin
      b[4*i +: 4] = 4'(m % 64'd10);
      if ((m % 64'd10) != 64'd0) nd = 5'(i + 1);
      m = m / 64'd10;
    end
  endfunction

  task automatic send(input logic [63:0] p, input logic s);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    product   = p;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid || lat > 200) break;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_take", out_valid, 1'b0);
    chk("in_ready_after_take", in_ready, 1'b1);
  endtask

  task automatic convert_check(input string tag, input logic [63:0] p, input logic s,
                               input logic [79:0] eb, input logic en, input logic [4:0] end_);
    int lat;
    send(p, s);
    wait_result(lat);
    chk({tag, "_latency"}, lat, 65);
    chk({tag, "_bcd"}, bcd, eb);
    chk({tag, "_neg"}, neg, en);
    chk({tag, "_ndigits"}, ndigits, end_);
    $display("conv %s p=%h s=%0d -> bcd=%h neg=%0d nd=%0d lat=%0d", tag, p, s, bcd, neg, ndigits, lat);
    take();
  endtask

  initial begin
    logic [79:0] eb;
    logic        en;
    logic [4:0]  end_;
    logic [63:0] p;
    logic        s;
    int          lat;
    int          seen;
    int          t[3];
    logic [63:0] b2b[3];

    vt[0] = '{64'd975,                 1'b0, 80'h975,                  1'b0, 5'd3};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'h1,                    1'b1, 5'd1};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 80'h18446744073709551615, 1'b0, 5'd20};
    vt[3] = '{64'h8000_0000_0000_0000, 1'b1, 80'h9223372036854775808,  1'b1, 5'd19};
    vt[4] = '{64'd0,                   1'b1, 80'h0,                    1'b0, 5'd1};
    vt[5] = '{64'hFFFF_FFFF_FFFF_CFC7, 1'b1, 80'h12345,                1'b1, 5'd5};
    vt[6] = '{64'd10,                  1'b0, 80'h10,                   1'b0, 5'd2};
    vt[7] = '{64'd9,                   1'b1, 80'h9,                    1'b0, 5'd1};
    vt[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 80'h9223372036854775807,  1'b0, 5'd19};
    vt[9] = '{64'h8AC7_2304_89E8_0000, 1'b0, 80'h10000000000000000000, 1'b0, 5'd20};

    reset = 1'b1; in_valid = 1'b0; product = '0; is_signed = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_bcd", bcd, 80'h0);
    chk("reset_neg", neg, 1'b0);
    chk("reset_ndigits", ndigits, 5'd0);

    for (int i = 0; i < 10; i++)
      convert_check($sformatf("vec%0d", i), vt[i].p, vt[i].s, vt[i].b, vt[i].n, vt[i].nd);

    for (int i = 0; i < 30; i++) begin
      p = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: p = 64'($urandom_range(0, 999));
        1: p = p >> $urandom_range(1, 63);
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      model(p, s, eb, en, end_);
      convert_check($sformatf("rnd%0d", i), p, s, eb, en, end_);
    end

    // Backpressure: hold the result, ignore a new request while DONE.
    model(64'd975, 1'b0, eb, en, end_);
    send(64'd975, 1'b0);
    wait_result(lat);
    chk("bp_latency", lat, 65);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) in_valid = 1'b1;
      if (i == 4) in_valid = 1'b0;
      if (i == 3) product = 64'd123;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold_bcd%0d", i), bcd, eb);
      chk($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("bp_hold_in_ready%0d", i), in_ready, 1'b0);
      chk($sformatf("bp_hold_nd%0d", i), ndigits, end_);
    end
    $display("backpressure held bcd=%h nd=%0d", bcd, ndigits);
    take();
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    chk("bp_pulse_ignored", seen, 0);

    // Reset during SHIFT discards the conversion.
    send(64'hFFFF_FFFF_FFFF_0000, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_bcd", bcd, 80'h0);
    chk("midrst_neg", neg, 1'b0);
    chk("midrst_ndigits", ndigits, 5'd0);
    $display("mid-conversion reset: out_valid=%0d in_ready=%0d bcd=%h nd=%0d", out_valid, in_ready, bcd, ndigits);
    convert_check("after_rst", 64'd12345, 1'b0, 80'h12345, 1'b0, 5'd5);

    // Back-to-back with out_ready held high.
    b2b[0] = 64'd1; b2b[1] = 64'hFFFF_FFFF_FFFF_FFFE; b2b[2] = 64'd4294967296;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model(b2b[k], 1'b1, eb, en, end_);
      send(b2b[k], 1'b1);
      wait_result(lat);
      t[k] = cyc;
      chk($sformatf("b2b%0d_bcd", k), bcd, eb);
      chk($sformatf("b2b%0d_neg", k), neg, en);
      chk($sformatf("b2b%0d_nd", k), ndigits, end_);
      $display("b2b %0d bcd=%h neg=%0d nd=%0d at cycle %0d", k, bcd, neg, ndigits, t[k]);
    end
    chk("b2b_spacing01", t[1] - t[0], 67);
    chk("b2b_spacing12", t[2] - t[1], 67);
    @(negedge clk);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
